// File: rtl/avalon_wait_ram.sv
// Word-organised simulation RAM on an Avalon-MM slave port with a programmable waitrequest stall,
// plus a side-band preload strobe and a whole-array clear for installing programs.
module avalon_wait_ram #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_byteenable,
    output logic        o_waitrequest,
    output logic [31:0] o_readdata,
    input  logic        i_load_en,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data,
    input  logic        i_mem_clear
);

    localparam int          DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  LOAD  = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [31:0]            r_readdata;
    logic [31:0]            r_mem [0:DEPTH-1];

    logic                   w_req;
    logic                   w_is_read;
    logic                   w_commit;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [ADDR_BITS-1:0]   w_load_idx;
    logic                   w_unused;

    assign w_req      = i_read | i_write;
    assign w_is_read  = i_read & ~i_write;
    assign w_commit   = (r_state == S_READY) && i_write;
    assign w_idx      = i_address[ADDR_BITS+1:2];
    assign w_load_idx = i_load_addr[ADDR_BITS+1:2];
    assign w_unused   = &{1'b0, i_address[31:ADDR_BITS+2], i_address[1:0],
                          i_load_addr[31:ADDR_BITS+2], i_load_addr[1:0]};

    assign o_waitrequest = w_req && (r_state != S_READY);
    assign o_readdata    = r_readdata;

    // The IDLE cycle that sees the request is the first stall cycle, so WAIT
    // hands over to READY once the counter reaches 1 (or IDLE does so directly
    // for a single-cycle stall). The read capture shares that edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cnt <= LOAD;
                        if (WAIT_CYCLES == 1) begin
                            r_state <= S_READY;
                            if (w_is_read)
                                r_readdata <= r_mem[w_idx];
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= S_READY;
                        if (w_is_read)
                            r_readdata <= r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_READY: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is never reset; clear beats preload beats bus write on the same word.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_mem_clear) begin
                r_mem[i] <= 32'h0;
            end else if (i_load_en && (w_load_idx == i[ADDR_BITS-1:0])) begin
                r_mem[i] <= i_load_data;
            end else if (w_commit && (w_idx == i[ADDR_BITS-1:0])) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_byteenable[b])
                        r_mem[i][8*b +: 8] <= i_writedata[8*b +: 8];
                end
            end
        end
    end

endmodule
